// File: rtl/pdm_density_pkg.sv
// pdm_density_pkg: shared widths and hysteresis target encoding for pdm_density_meter.
package pdm_density_pkg;

    typedef enum logic [1:0] {
        TGT_HOLD = 2'd0,
        TGT_SET  = 2'd1,
        TGT_CLR  = 2'd2
    } tgt_e;

    function automatic int cnt_w(input int win_log2);
        return win_log2 + 1;
    endfunction

    function automatic int run_w(input int deb);
        return (deb < 1) ? 1 : $clog2(deb + 1);
    endfunction

endpackage

// File: rtl/pdm_density_chan.sv
// pdm_density_chan: one channel's ones accumulator, hysteresis compare and optional debounce.
// PDM_DENSITY_DEBOUNCE_EN enables the consecutive-window debounce on det.
module pdm_density_chan
    import pdm_density_pkg::*;
#(
    parameter  int WIN_LOG2 = 8,
    parameter  int DEB      = 2,
    localparam int CNT_W    = cnt_w(WIN_LOG2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sig,
    input  logic             win_end,
    input  logic [CNT_W-1:0] thr_hi,
    input  logic [CNT_W-1:0] thr_lo,
    output logic [CNT_W-1:0] count,
    output logic             det
);

    localparam int RUN_W = run_w(DEB);
`ifdef PDM_DENSITY_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic [CNT_W-1:0] acc_q, acc_d, count_q, count_d, total;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             det_q, det_d, want, flip;
    tgt_e             tgt;

    assign total = acc_q + CNT_W'(sig);
    // Set is tested first so an inverted threshold pair still resolves to 1.
    assign tgt   = (total >= thr_hi) ? TGT_SET : (total < thr_lo) ? TGT_CLR : TGT_HOLD;
    assign want  = (tgt == TGT_SET) || ((tgt == TGT_HOLD) && det_q);

    assign run_inc = run_q + 1'b1;
    assign flip    = (want != det_q) && (run_inc == RUN_W'(DEB));

    assign acc_d   = (clr || win_end) ? '0 : total;
    assign count_d = win_end ? total : count_q;
    assign run_d   = !DEB_EN ? '0 : !win_end ? run_q : ((want == det_q) || flip) ? '0 : run_inc;
    assign det_d   = !win_end ? det_q : !DEB_EN ? want : flip ? ~det_q : det_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            count_q <= '0;
            run_q   <= '0;
            det_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            run_q   <= run_d;
            det_q   <= det_d;
        end
    end

    assign count = count_q;
    assign det   = det_q;

endmodule

// File: rtl/pdm_density_meter.sv
// pdm_density_meter: multi-channel pulse-density meter with shared window counter and strobe.
// Define PDM_DENSITY_DEBOUNCE_EN to require DEB agreeing windows before det changes.
module pdm_density_meter
    import pdm_density_pkg::*;
#(
    parameter  int CH       = 1,
    parameter  int WIN_LOG2 = 8,
    parameter  int DEB      = 2,
    localparam int CNT_W    = cnt_w(WIN_LOG2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [CH-1:0]       sig_in,
    input  logic [CNT_W-1:0]    thr_hi,
    input  logic [CNT_W-1:0]    thr_lo,
    output logic [CH*CNT_W-1:0] count,
    output logic                count_valid,
    output logic [CH-1:0]       det
);

    logic [WIN_LOG2-1:0] win_q, win_d;
    logic                valid_q, win_end;

    // A clear on the last sample of a window suppresses that window's publication.
    assign win_end = (&win_q) && !clr;
    assign win_d   = clr ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            valid_q <= win_end;
        end
    end

    assign count_valid = valid_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pdm_density_chan #(
            .WIN_LOG2(WIN_LOG2),
            .DEB     (DEB)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .sig    (sig_in[i]),
            .win_end(win_end),
            .thr_hi (thr_hi),
            .thr_lo (thr_lo),
            .count  (count[i*CNT_W +: CNT_W]),
            .det    (det[i])
        );
    end

endmodule

// File: tb/tb_pdm_density_meter.sv
// tb_pdm_density_meter: scoreboard bench for pdm_density_meter with CH=2, WIN_LOG2=4.
module tb_pdm_density_meter;

    localparam int DEB = 2;

    typedef struct packed {
        logic [9:0] cnt;
        logic [1:0] det;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] sig_in = 2'b00;
    logic [4:0] thr_hi = 5'd8;
    logic [4:0] thr_lo = 5'd8;
    logic [9:0] count;
    logic       count_valid;
    logic [1:0] det;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t last;
    int   mwin;
    int   macc[2];
    int   mrun[2];
    logic [1:0] mdet;

    always #5 clk = ~clk;

    pdm_density_meter #(
        .CH      (2),
        .WIN_LOG2(4),
        .DEB     (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sig_in     (sig_in),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .count      (count),
        .count_valid(count_valid),
        .det        (det)
    );

    task automatic model_det(input int ch, input int t);
        logic tg;
        tg = (t >= int'(thr_hi)) ? 1'b1 : (t < int'(thr_lo)) ? 1'b0 : mdet[ch];
`ifdef PDM_DENSITY_DEBOUNCE_EN
        if (tg == mdet[ch]) mrun[ch] = 0;
        else begin
            mrun[ch] += 1;
            if (mrun[ch] == DEB) begin
                mdet[ch] = ~mdet[ch];
                mrun[ch] = 0;
            end
        end
`else
        mdet[ch] = tg;
`endif
    endtask

    task automatic step(input logic [1:0] b, input logic c);
        logic ev;
        exp_t e;
        e = '0;
        sig_in = b;
        clr = c;
        ev = !c && (mwin == 15);
        if (c) begin
            macc[0] = 0;
            macc[1] = 0;
            mwin = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) macc[ch] += int'(b[ch]);
            if (ev) begin
                for (int ch = 0; ch < 2; ch++) begin
                    model_det(ch, macc[ch]);
                    e.cnt[ch*5 +: 5] = macc[ch][4:0];
                    macc[ch] = 0;
                end
                e.det = mdet;
                sb.push_back(e);
            end
            mwin = (mwin + 1) % 16;
        end
        @(posedge clk);
        #1;
        total++;
        if (count_valid !== ev) begin
            bad++;
            $display("FAIL valid_strobe t=%0t got=%b exp=%b", $time, count_valid, ev);
        end
        if (ev) begin
            e = sb.pop_front();
            total += 2;
            if (count !== e.cnt) begin
                bad++;
                $display("FAIL sb_count t=%0t got=%h exp=%h", $time, count, e.cnt);
            end
            if (det !== e.det) begin
                bad++;
                $display("FAIL sb_det t=%0t got=%b exp=%b", $time, det, e.det);
            end
            last = e;
        end
        clr = 1'b0;
    endtask

    task automatic window(input int n0, input int n1);
        for (int i = 0; i < 16; i++) step({(i < n1), (i < n0)}, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        sig_in = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (count !== 10'd0) begin bad++; $display("FAIL rst_count got=%h exp=0", count); end
        if (count_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", count_valid); end
        if (det !== 2'b00) begin bad++; $display("FAIL rst_det got=%b exp=00", det); end
        mwin = 0;
        macc = '{0, 0};
        mrun = '{0, 0};
        mdet = 2'b00;
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        thr_hi = 5'd8;
        thr_lo = 5'd8;
        window(16, 16);
        total++;
        if (count !== {5'd16, 5'd16}) begin bad++; $display("FAIL first_window got=%h exp=%h", count, {5'd16, 5'd16}); end
    endtask

    task automatic test_scale();
        window(16, 0);
        total += 2;
        if (count !== {5'd0, 5'd16}) begin bad++; $display("FAIL scale_count got=%h exp=%h", count, {5'd0, 5'd16}); end
        if (det !== 2'b01) begin bad++; $display("FAIL scale_det got=%b exp=01", det); end
    endtask

    task automatic test_hysteresis();
        int   ones[4] = '{12, 8, 5, 8};
        logic want[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        thr_hi = 5'd10;
        thr_lo = 5'd6;
        for (int k = 0; k < 4; k++) begin
            window(ones[k], 0);
`ifndef PDM_DENSITY_DEBOUNCE_EN
            total++;
            if (det[0] !== want[k]) begin bad++; $display("FAIL hyst_w%0d got=%b exp=%b", k, det[0], want[k]); end
`endif
        end
    endtask

    task automatic test_clear();
        window(16, 16);
        for (int i = 0; i < 7; i++) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        total += 2;
        if (count !== last.cnt) begin bad++; $display("FAIL clr_hold_count got=%h exp=%h", count, last.cnt); end
        if (det !== last.det) begin bad++; $display("FAIL clr_hold_det got=%b exp=%b", det, last.det); end
        window(16, 16);
        total++;
        if (count !== {5'd16, 5'd16}) begin bad++; $display("FAIL clr_window got=%h exp=%h", count, {5'd16, 5'd16}); end
        for (int i = 0; i < 15; i++) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        window(3, 9);
    endtask

    task automatic test_debounce();
`ifdef PDM_DENSITY_DEBOUNCE_EN
        int   ones[4] = '{12, 4, 12, 12};
        logic want[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        thr_hi = 5'd10;
        thr_lo = 5'd6;
        for (int k = 0; k < 4; k++) begin
            window(ones[k], 0);
            total++;
            if (det[0] !== want[k]) begin bad++; $display("FAIL deb_w%0d got=%b exp=%b", k, det[0], want[k]); end
        end
`endif
    endtask

    task automatic test_inversion();
        int nwin;
`ifdef PDM_DENSITY_DEBOUNCE_EN
        nwin = DEB;
`else
        nwin = 1;
`endif
        do_reset();
        thr_lo = 5'd12;
        thr_hi = 5'd4;
        repeat (nwin) window(8, 8);
        total++;
        if (det !== 2'b11) begin bad++; $display("FAIL inversion got=%b exp=11", det); end
    endtask

    task automatic test_back_to_back();
        int n0, n1;
        for (int w = 0; w < 8; w++) begin
            n0 = $urandom_range(0, 16);
            n1 = $urandom_range(0, 16);
            thr_hi = 5'($urandom_range(0, 17));
            thr_lo = 5'($urandom_range(0, 17));
            for (int i = 0; i < 16; i++) begin
                if (i == 8) begin
                    thr_hi = 5'($urandom_range(0, 17));
                    thr_lo = 5'($urandom_range(0, 17));
                end
                step({(i < n1), (i < n0)}, 1'b0);
            end
        end
        for (int i = 0; i < 9; i++) step(2'b11, 1'b0);
        do_reset();
        window(5, 11);
    endtask

    initial begin
        test_reset();
        test_scale();
        test_hysteresis();
        test_clear();
        test_debounce();
        test_inversion();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_density_meter.md
# pdm_density_meter

Multi-channel pulse-density meter for 1-bit digitized streams (LVDS comparator / sigma-delta bitstreams). Each channel counts ones over a fixed power-of-two window, publishes the count with a one-cycle valid strobe, and drives a detect flag with programmable hysteresis. It sits between the digitizer and downstream phase/amplitude logic or the TX pin, and generalises the fixed 256-sample, half-scale threshold detector to N channels, any window length and runtime thresholds.

## Interface
- `CH`, 1: number of independent input channels.
- `WIN_LOG2`, 8: window length is 2^WIN_LOG2 samples; legal range 2..16.
- `DEB`, 2: consecutive agreeing windows required before `det` changes. Used only with the debounce feature.
- `clk`  in  1  sample clock; one sample per channel per rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous window restart.
- `sig_in`  in  CH  digitized bitstreams; bit i is channel i.
- `thr_hi`  in  WIN_LOG2+1  set threshold, shared by all channels.
- `thr_lo`  in  WIN_LOG2+1  clear threshold, shared by all channels.
- `count`  out  CH*(WIN_LOG2+1)  last completed window count per channel; channel i occupies slice i.
- `count_valid`  out  1  one-cycle strobe when `count` updates.
- `det`  out  CH  per-channel detect flag.

## Operation
- A shared window counter `win` runs 0..2^WIN_LOG2−1 and wraps. Each channel adds `sig_in[i]` to its accumulator every cycle.
- Accumulator and count width are CNT_W = WIN_LOG2+1, so the full-scale value 2^WIN_LOG2 is representable. There is no wrap and no saturation.
- Window end (`win` = max): per channel, total = acc + sig_in[i].
  - Registers: count ← total; acc ← 0; count_valid ← 1 on the next edge.
- Hysteresis, evaluated on each total:
  - total ≥ thr_hi → target 1.
  - otherwise total < thr_lo → target 0.
  - otherwise hold.
  - Set takes priority if thr_lo > thr_hi (misconfiguration).
  - Without debounce, det ← target together with count.
- `clr`:
  - Sets win ← 0 and all accumulators to 0.
  - `count`, `det` and debounce state are untouched.
  - The sample present on the `clr` cycle is discarded.
  - `clr` on a window-end cycle wins: no count update and no valid pulse.
- Thresholds are sampled only at window end. Changing them mid-window is legal.
- Reset: win, acc, count, count_valid, det and debounce state all 0.

## Timing
- `count_valid` is high for exactly one cycle every 2^WIN_LOG2 cycles, and stays low while `clr` is held.
- Latency: the last sample of a window is reflected in `count`/`det` on the edge that raises `count_valid`. Both are stable from then until the next strobe.
- First strobe after reset release: the first sample is taken on the first rising edge with `rst` high. `count_valid` rises on the 2^WIN_LOG2-th such edge.
- Reset asserted mid-window: the partial window is lost and no strobe is generated.

## Configuration
- Macro `PDM_DENSITY_DEBOUNCE_EN`.
- Defined: per channel, a run counter of width clog2(DEB+1) counts consecutive windows whose hysteresis target differs from the current `det`.
  - `det` toggles when the run reaches DEB, and the run counter resets.
  - A window whose target equals `det` resets the run to 0.
  - `clr` does not reset the run counter.
- Undefined: `det` follows the target every window, and `DEB` is ignored.

## Structure
- Package `pdm_density_pkg`:
  - `cnt_w(win_log2)` function.
  - Debounce run-counter width function.
  - Target encoding constants (`TGT_SET`, `TGT_CLR`, `TGT_HOLD`).
- Sub-module `pdm_density_chan`, instantiated CH times by generate. It holds the accumulator, hysteresis compare and debounce.
- The top level owns `win`, `clr` handling and `count_valid`.

## Test plan
All scenarios use CH=2 and WIN_LOG2=4 (16 samples, CNT_W=5).
- **Reset:** hold `rst` low with sig_in=2'b11 → count=0, count_valid=0, det=0. After release, first strobe on edge 16 with count={16,16}.
- **Full and zero scale:** ch0 all ones, ch1 all zeros, thr_hi=8, thr_lo=8 → count ch0=16 (no wrap), ch1=0; det=2'b01.
- **Hysteresis:** thr_hi=10, thr_lo=6; ch0 windows carry 12, 8, 5, 8 ones → det0 = 1, 1, 0, 0.
- **Clear:** pulse `clr` at win=7 with all ones → next strobe exactly 16 cycles after the `clr` cycle, count=16, prior det/count held. Also `clr` at win=15 → no strobe that window.
- **Debounce** (`PDM_DENSITY_DEBOUNCE_EN`, DEB=2, thr_hi=10, thr_lo=6): windows 12, 4, 12, 12 → det stays 0 through the third strobe and rises on the fourth.
- **Threshold inversion:** thr_lo=12, thr_hi=4, window of 8 ones → det=1.
